// File: rtl/e203_exu_longp_div.sv
// e203_exu_longp_div: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Retires through the long-pipe write-back handshake and holds its result until accepted.
module e203_exu_longp_div #(
  parameter int XLEN       = 32,
  parameter int ITAG_WIDTH = 1,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_i_valid,
  output logic                  div_i_ready,
  input  logic [1:0]            div_i_op,
  input  logic [XLEN-1:0]       div_i_rs1,
  input  logic [XLEN-1:0]       div_i_rs2,
  input  logic [ITAG_WIDTH-1:0] div_i_itag,
  input  logic                  div_flush,
  output logic                  div_busy,
  output logic                  div_wbck_o_valid,
  input  logic                  div_wbck_o_ready,
  output logic [XLEN-1:0]       div_wbck_o_wdat,
  output logic                  div_wbck_o_err,
  output logic [ITAG_WIDTH-1:0] div_wbck_o_itag
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ITAG_WIDTH-1:0] itag_q, itag_d;
  logic [XLEN-1:0]       quo_q, quo_d, dvs_q, dvs_d, wdat_q, wdat_d, qfix, rfix;
  logic [XLEN:0]         rem_q, rem_d, sht, sub;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  qneg_q, qneg_d, rneg_q, rneg_d, sgn, dz, ovf;
  assign div_i_ready      = (state_q == IDLE) & ~div_flush;
  assign div_busy         = state_q != IDLE;
  assign div_wbck_o_valid = state_q == DONE;
  assign div_wbck_o_wdat  = wdat_q;
  assign div_wbck_o_itag  = itag_q;
  assign div_wbck_o_err   = 1'b0;
  assign sgn  = ~div_i_op[0];
  assign dz   = div_i_rs2 == '0;
  assign ovf  = sgn & (div_i_rs1 == MIN) & (&div_i_rs2);
  // Quotient bits shift in at the bottom of quo_q as dividend bits shift out the top.
  assign sht  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign sub  = sht - {1'b0, dvs_q};
  assign qfix = qneg_q ? -quo_q : quo_q;
  assign rfix = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    itag_d  = itag_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    wdat_d  = wdat_q;
    case (state_q)
      IDLE: if (div_i_valid & div_i_ready) begin
        op_d    = div_i_op;
        itag_d  = div_i_itag;
        quo_d   = (sgn & div_i_rs1[XLEN-1]) ? -div_i_rs1 : div_i_rs1;
        dvs_d   = (sgn & div_i_rs2[XLEN-1]) ? -div_i_rs2 : div_i_rs2;
        rem_d   = '0;
        cnt_d   = '0;
        qneg_d  = sgn & (div_i_rs1[XLEN-1] ^ div_i_rs2[XLEN-1]);
        rneg_d  = sgn & div_i_rs1[XLEN-1];
        wdat_d  = dz ? (div_i_op[1] ? div_i_rs1 : '1) : (div_i_op[1] ? '0 : MIN);
        state_d = (dz | ovf) ? DONE : CALC;
      end
      CALC: begin
        rem_d   = sub[XLEN] ? sht : sub;
        quo_d   = {quo_q[XLEN-2:0], ~sub[XLEN]};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(XLEN-1)) ? FIX : CALC;
      end
      FIX: begin
        wdat_d  = op_q[1] ? rfix : qfix;
        state_d = DONE;
      end
      DONE: state_d = div_wbck_o_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (div_flush & (state_q != IDLE)) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      itag_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      itag_q  <= itag_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      wdat_q  <= wdat_d;
    end
  end
endmodule

// File: tb/tb_e203_exu_longp_div.sv
// tb_e203_exu_longp_div: randomized and directed checks of the divider against an arithmetic model.
module tb_e203_exu_longp_div;
  logic        clk = 0, rst = 1;
  logic        div_i_valid = 0, div_i_ready, div_flush = 0, div_busy;
  logic [1:0]  div_i_op = 0;
  logic [31:0] div_i_rs1 = 0, div_i_rs2 = 0, div_wbck_o_wdat;
  logic        div_i_itag = 0, div_wbck_o_itag, div_wbck_o_valid, div_wbck_o_ready = 0, div_wbck_o_err;
  int pass_n = 0, total_n = 0;
  e203_exu_longp_div dut (
    .clk(clk), .rst(rst), .div_i_valid(div_i_valid), .div_i_ready(div_i_ready),
    .div_i_op(div_i_op), .div_i_rs1(div_i_rs1), .div_i_rs2(div_i_rs2), .div_i_itag(div_i_itag),
    .div_flush(div_flush), .div_busy(div_busy), .div_wbck_o_valid(div_wbck_o_valid),
    .div_wbck_o_ready(div_wbck_o_ready), .div_wbck_o_wdat(div_wbck_o_wdat),
    .div_wbck_o_err(div_wbck_o_err), .div_wbck_o_itag(div_wbck_o_itag)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : 32'h80000000;
    if (op[0]) return op[1] ? a % b : a / b;
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction
  function automatic bit special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic tag);
    @(negedge clk);
    total_n++;
    if (div_i_ready !== 1'b1) $display("FAIL accept_ready: div_i_ready=%b want 1", div_i_ready);
    else pass_n++;
    div_i_valid = 1; div_i_op = op; div_i_rs1 = a; div_i_rs2 = b; div_i_itag = tag;
    @(posedge clk);
    #1 div_i_valid = 0;
  endtask
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic tag, input int hold);
    int n;
    logic [31:0] exp_w;
    exp_w = model(op, a, b);
    start_op(op, a, b, tag);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!div_wbck_o_valid && n < 100);
    total_n++;
    if (n !== (special(op, a, b) ? 1 : 34)) $display("FAIL latency op=%0d %h/%h: got %0d want %0d", op, a, b, n, special(op, a, b) ? 1 : 34);
    else pass_n++;
    if (!div_wbck_o_valid) return;
    total_n++;
    if (div_wbck_o_wdat !== exp_w || div_wbck_o_itag !== tag || div_wbck_o_err !== 1'b0)
      $display("FAIL result op=%0d %h/%h: wdat=%h itag=%b err=%b want %h %b 0", op, a, b, div_wbck_o_wdat, div_wbck_o_itag, div_wbck_o_err, exp_w, tag);
    else pass_n++;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total_n++;
      if (div_wbck_o_valid !== 1 || div_wbck_o_wdat !== exp_w || div_wbck_o_itag !== tag || div_i_ready !== 0)
        $display("FAIL hold cycle %0d: valid=%b wdat=%h itag=%b rdy=%b want 1 %h %b 0", i, div_wbck_o_valid, div_wbck_o_wdat, div_wbck_o_itag, div_i_ready, exp_w, tag);
      else pass_n++;
    end
    div_wbck_o_ready = 1;
    @(negedge clk);
    div_wbck_o_ready = 0;
    total_n++;
    if (div_wbck_o_valid !== 0 || div_i_ready !== 1) $display("FAIL post_handshake: valid=%b rdy=%b want 0 1", div_wbck_o_valid, div_i_ready);
    else pass_n++;
  endtask
  task automatic no_valid_for(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (div_wbck_o_valid) seen++;
    end
    total_n++;
    if (seen != 0) $display("FAIL %s: stale valid seen %0d cycles want 0", name, seen);
    else pass_n++;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total_n++;
    if (div_wbck_o_valid !== 0 || div_busy !== 0 || div_wbck_o_wdat !== 0 || div_wbck_o_itag !== 0 || div_wbck_o_err !== 0 || div_i_ready !== 1)
      $display("FAIL reset: valid=%b busy=%b wdat=%h itag=%b err=%b rdy=%b", div_wbck_o_valid, div_busy, div_wbck_o_wdat, div_wbck_o_itag, div_wbck_o_err, div_i_ready);
    else pass_n++;
  endtask
  task automatic test_basic();
    run_op(2'b01, 100, 7, 1, 0);
    run_op(2'b11, 100, 7, 0, 0);
    run_op(2'b00, 32'hFFFFFFF9, 2, 1, 0);
    run_op(2'b10, 32'hFFFFFFF9, 2, 0, 0);
    run_op(2'b00, 7, 32'hFFFFFFFE, 1, 0);
  endtask
  task automatic test_special();
    run_op(2'b00, 5, 0, 1, 0);
    run_op(2'b11, 5, 0, 0, 0);
    run_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, 1, 0);
  endtask
  task automatic test_backpressure();
    run_op(2'b00, 32'h12345678, 32'hFFFFF000, 1, 20);
  endtask
  task automatic test_flush();
    @(negedge clk);
    div_flush = 1;
    #1;
    total_n++;
    if (div_i_ready !== 0) $display("FAIL idle_flush_ready: rdy=%b want 0", div_i_ready);
    else pass_n++;
    div_flush = 0;
    start_op(2'b01, 32'hDEADBEEF, 3, 1);
    repeat (11) @(negedge clk);
    div_flush = 1;
    @(negedge clk);
    div_flush = 0;
    total_n++;
    if (div_busy !== 0 || div_wbck_o_valid !== 0) $display("FAIL flush_calc: busy=%b valid=%b want 0 0", div_busy, div_wbck_o_valid);
    else pass_n++;
    no_valid_for("flush_calc_stale", 50);
    run_op(2'b01, 9, 3, 0, 0);
  endtask
  task automatic test_rst_mid();
    int n = 0;
    start_op(2'b00, 32'h7FFFFFFF, 13, 1);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    total_n++;
    if (div_wbck_o_valid !== 0 || div_i_ready !== 1) $display("FAIL rst_calc: valid=%b rdy=%b want 0 1", div_wbck_o_valid, div_i_ready);
    else pass_n++;
    no_valid_for("rst_calc_stale", 40);
    start_op(2'b01, 1000, 10, 1);
    while (!div_wbck_o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    total_n++;
    if (div_wbck_o_valid !== 0 || div_i_ready !== 1) $display("FAIL rst_done: valid=%b rdy=%b want 0 1", div_wbck_o_valid, div_i_ready);
    else pass_n++;
    no_valid_for("rst_done_stale", 5);
  endtask
  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = $urandom_range(1, 20);
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: b = -$urandom_range(1, 20);
        default: ;
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
